dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// Two-port arbiter and sequencer in front of the single-ported data memory.
// Port 0 is the pipeline MEM stage. Port 1 is a secondary master (debug/loader).
// Grants the memory to one requester at a time, round-robin, and drives the memory's
// write strobe, read strobe, address and write data. Registers read data and
// returns it with a one-cycle ack.
// PARAMETERS
// ADDR_W  32  requester/memory address width
// DATA_W  32  data width
// DEPTH   16  number of valid memory words; addresses >= DEPTH are rejected
// PORTS
// clk        in   1       clock, all state on posedge
// rst        in   1       asynchronous, active-high reset
// p0_req     in   1       port 0 request; held high until p0_ack
// p0_we      in   1       port 0: 1=write, 0=read
// p0_addr    in   ADDR_W  port 0 word address
// p0_wdata   in   DATA_W  port 0 write data
// p0_ack     out  1       port 0 transaction complete (1-cycle pulse)
// p0_rdata   out  DATA_W  port 0 read data, valid while p0_ack=1
// p0_err     out  1       port 0 address out of range, valid while p0_ack=1
// p1_*       ...  ...     identical set for port 1
// mem_we     out  1       memory write strobe
// mem_re     out  1       memory read strobe
// mem_addr   out  ADDR_W  memory address
// mem_wdata  out  DATA_W  memory write data
// mem_rdata  in   DATA_W  memory read data (combinational from mem_addr/mem_re)
// BEHAVIOUR
// - Reset (async): state=IDLE, last_grant=1 (so port 0 wins first), all outputs 0, latches 0.
// - FSM IDLE -> ACCESS -> DONE -> IDLE.
//   - IDLE: if any req, choose winner, latch its we/addr/wdata and id, go to ACCESS. Else stay.
//   - ACCESS: one cycle. mem_addr/mem_wdata come from the latch. mem_we=latched we and
//     mem_re=!latched we, both only if addr<DEPTH. At the closing edge mem_rdata is
//     captured (read) or the memory commits the write. Go to DONE.
//   - DONE: winner's ack=1 for exactly one cycle, with rdata (reads; 0 for writes or
//     error) and err. last_grant=winner. Go to IDLE.
// - Strobes and mem_addr/mem_wdata are 0 outside ACCESS.
// - Latency: req sampled high at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2.
//   Max throughput: 1 transaction per 3 cycles.
// - Arbitration: if only one req, it wins. If both, the port != last_grant wins
//   (strict alternation under contention).
// - Requesters must hold req/we/addr/wdata stable until ack. Inputs are sampled only
//   in IDLE, so later changes have no effect on the granted transaction.
// - A req still high in the IDLE cycle after ack is a new transaction.
// - The losing requester waits with req high; no ack is issued to it meanwhile.
// - Out of range (addr >= DEPTH, full ADDR_W compare): no mem strobe in ACCESS,
//   ack with err=1, rdata=0.
// - rdata/err are held 0 when ack=0.
// - Reset mid-transaction (any state): strobes drop immediately, no ack issued,
//   pending transaction dropped. A write in ACCESS commits only if its clock edge
//   precedes reset assertion.
// TESTING
// 1. Reset: assert rst mid-ACCESS of a write -> mem_we=0 at once, no p0_ack, state IDLE, last_grant=1.
// 2. p0 write addr=3 data=0xDEADBEEF, then p0 read addr=3 -> second p0_ack with p0_rdata=0xDEADBEEF,
//    ack 2 cycles after req sampled.
// 3. p0_req and p1_req rise same cycle after reset -> p0 acked first, then p1. Both held
//    continuously -> acks alternate p0,p1,p0,p1 every 3 cycles.
// 4. p1 read addr=16 (DEPTH=16) -> mem_re/mem_we stay 0, p1_ack=1 with p1_err=1, p1_rdata=0.
// 5. p1 alone requests 4 times back-to-back -> p1 granted each time (no idle gap beyond FSM),
//    p0 outputs stay 0.
// 6. p0 changes addr/wdata during ACCESS -> memory sees originally latched values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer for a single-ported data memory.
// Each transaction takes IDLE -> ACCESS -> DONE, with a one-cycle ack in DONE.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              lat_we_q, lat_we_d;
    logic              lat_err_q, lat_err_d;
    logic              lat_id_q, lat_id_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic              p0_err_q, p0_err_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p1_err_q, p1_err_d;

    logic              win_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [DATA_W-1:0] rd_value;

    // Winner selection: lone requester wins, contention alternates away from last grant.
    assign win_id       = (p0_req && p1_req) ? ~last_grant_q : ~p0_req;
    assign sel_we       = win_id ? p1_we    : p0_we;
    assign sel_addr     = win_id ? p1_addr  : p0_addr;
    assign sel_wdata    = win_id ? p1_wdata : p0_wdata;
    assign sel_in_range = (sel_addr < ADDR_W'(DEPTH));
    assign rd_value     = (!lat_we_q && !lat_err_q) ? mem_rdata : '0;

    // Next-state and registered-output logic; strobes/acks default low every cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_we_d     = lat_we_q;
        lat_err_d    = lat_err_q;
        lat_id_d     = lat_id_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        p0_ack_d     = 1'b0;
        p0_rdata_d   = '0;
        p0_err_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p1_rdata_d   = '0;
        p1_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    lat_we_d    = sel_we;
                    lat_err_d   = ~sel_in_range;
                    lat_id_d    = win_id;
                    mem_we_d    = sel_we & sel_in_range;
                    mem_re_d    = ~sel_we & sel_in_range;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (lat_id_q) begin
                    p1_ack_d   = 1'b1;
                    p1_rdata_d = rd_value;
                    p1_err_d   = lat_err_q;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = rd_value;
                    p0_err_d   = lat_err_q;
                end
                last_grant_d = lat_id_q;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops strobes and any pending transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            lat_we_q     <= 1'b0;
            lat_err_q    <= 1'b0;
            lat_id_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            p0_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p0_err_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p1_rdata_q   <= '0;
            p1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_we_q     <= lat_we_d;
            lat_err_q    <= lat_err_d;
            lat_id_q     <= lat_id_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            p0_ack_q     <= p0_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p0_err_q     <= p0_err_d;
            p1_ack_q     <= p1_ack_d;
            p1_rdata_q   <= p1_rdata_d;
            p1_err_q     <= p1_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign p0_ack    = p0_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_ack    = p1_ack_q;
    assign p1_rdata  = p1_rdata_q;
    assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a transaction-level reference model and per-cycle compare.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_ack, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_ack, p1_err;
    logic [31:0] p1_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    logic [31:0] tb_mem [16];
    logic [31:0] ref_mem [16];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: combinational read, write on clock edge while strobed.
    assign mem_rdata = (mem_re && mem_addr < 32'd16) ? tb_mem[mem_addr[3:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd16) tb_mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a granted transaction occupies the memory for one cycle, then acks.
    logic        e_mem_we = 0, e_mem_re = 0;
    logic [31:0] e_mem_addr = 0, e_mem_wdata = 0;
    logic        e_p0_ack = 0, e_p0_err = 0, e_p1_ack = 0, e_p1_err = 0;
    logic [31:0] e_p0_rdata = 0, e_p1_rdata = 0;
    int          since_grant = 0;
    int          m_port;
    logic        m_last = 1'b1;
    logic        m_we, m_inr;
    logic [31:0] m_addr, m_wdata, m_rd;

    always @(posedge clk or posedge rst) begin
        e_mem_we = 0; e_mem_re = 0; e_mem_addr = 0; e_mem_wdata = 0;
        e_p0_ack = 0; e_p0_err = 0; e_p0_rdata = 0;
        e_p1_ack = 0; e_p1_err = 0; e_p1_rdata = 0;
        if (rst) begin
            since_grant = 0;
            m_last = 1'b1;
        end else if (since_grant == 0) begin
            if (p0_req || p1_req) begin
                if (p0_req && p1_req) m_port = (m_last == 1'b1) ? 0 : 1;
                else                  m_port = p0_req ? 0 : 1;
                m_we    = (m_port == 1) ? p1_we    : p0_we;
                m_addr  = (m_port == 1) ? p1_addr  : p0_addr;
                m_wdata = (m_port == 1) ? p1_wdata : p0_wdata;
                m_inr   = (m_addr < 32'd16);
                e_mem_we    = m_we && m_inr;
                e_mem_re    = !m_we && m_inr;
                e_mem_addr  = m_addr;
                e_mem_wdata = m_wdata;
                since_grant = 1;
            end
        end else if (since_grant == 1) begin
            m_rd = 0;
            if (m_inr) begin
                if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
                else      m_rd = ref_mem[m_addr[3:0]];
            end
            if (m_port == 0) begin
                e_p0_ack = 1; e_p0_rdata = m_rd; e_p0_err = !m_inr;
            end else begin
                e_p1_ack = 1; e_p1_rdata = m_rd; e_p1_err = !m_inr;
            end
            m_last = m_port[0];
            since_grant = 2;
        end else begin
            since_grant = 0;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        chk("mem_we", mem_we, e_mem_we);
        chk("mem_re", mem_re, e_mem_re);
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("p0_ack", p0_ack, e_p0_ack);
        chk("p0_rdata", p0_rdata, e_p0_rdata);
        chk("p0_err", p0_err, e_p0_err);
        chk("p1_ack", p1_ack, e_p1_ack);
        chk("p1_rdata", p1_rdata, e_p1_rdata);
        chk("p1_err", p1_err, e_p1_err);
    end

    // Ack log for ordering and spacing checks.
    int ack_port [$];
    int ack_cyc  [$];
    always @(negedge clk) begin
        if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance until the given port acks; returns the number of edges taken.
    task automatic wait_ack(input int port, input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = (port == 0) ? p0_ack : p1_ack;
        end
        if (!seen) begin
            n_vec++;
            n_mis++;
            $display("FAIL ack_timeout port %0d: no ack within %0d cycles", port, budget);
        end
    endtask

    task automatic p0_txn(input logic we, input logic [31:0] a, input logic [31:0] d, output int n);
        p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d;
        wait_ack(0, 6, n);
        p0_req = 0;
    endtask

    task automatic p1_txn(input logic we, input logic [31:0] a, input logic [31:0] d, output int n);
        p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d;
        wait_ack(1, 6, n);
        p1_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] exp_rd [4];
        logic [31:0] rd_addr [4];
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = 32'hA5A5_0000 + 32'(i);
            ref_mem[i] = 32'hA5A5_0000 + 32'(i);
        end
        #1 rst = 1;
        repeat (2) tick();
        rst = 0;

        // Reset in the middle of a write access.
        p0_req = 1; p0_we = 1; p0_addr = 32'd5; p0_wdata = 32'h1234_5678;
        tick();
        chk("t1_we_in_access", mem_we, 1);
        chk("t1_addr_in_access", mem_addr, 32'd5);
        rst = 1;
        #1;
        chk("t1_we_after_rst", mem_we, 0);
        chk("t1_ack_after_rst", p0_ack, 0);
        p0_req = 0;
        tick();
        rst = 0;
        repeat (2) tick();
        chk("t1_mem5_unchanged", tb_mem[5], 32'hA5A5_0005);

        // Write then read back on port 0.
        p0_txn(1, 32'd3, 32'hDEAD_BEEF, n);
        chk("t2_write_latency", n, 2);
        tick();
        p0_txn(0, 32'd3, 32'h0, n);
        chk("t2_read_latency", n, 2);
        chk("t2_read_data", p0_rdata, 32'hDEAD_BEEF);
        tick();

        // Contention from reset: strict alternation starting with port 0.
        rst = 1;
        tick();
        rst = 0;
        ack_port.delete();
        ack_cyc.delete();
        p0_req = 1; p0_we = 0; p0_addr = 32'd3;
        p1_req = 1; p1_we = 1; p1_addr = 32'd7; p1_wdata = 32'h0BAD_F00D;
        repeat (11) tick();
        p0_req = 0; p1_req = 0;
        repeat (2) tick();
        chk("t3_ack_count", ack_port.size(), 4);
        if (ack_port.size() == 4) begin
            chk("t3_order0", ack_port[0], 0);
            chk("t3_order1", ack_port[1], 1);
            chk("t3_order2", ack_port[2], 0);
            chk("t3_order3", ack_port[3], 1);
            for (int i = 1; i < 4; i++) chk("t3_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // Out-of-range read on port 1.
        p1_req = 1; p1_we = 0; p1_addr = 32'd16;
        tick();
        chk("t4_no_re", mem_re, 0);
        chk("t4_no_we", mem_we, 0);
        wait_ack(1, 4, n);
        p1_req = 0;
        chk("t4_latency", n, 1);
        chk("t4_err", p1_err, 1);
        chk("t4_rdata", p1_rdata, 32'h0);
        tick();

        // Port 1 alone, four back-to-back reads with req held high.
        rd_addr[0] = 32'd3;  exp_rd[0] = 32'hDEAD_BEEF;
        rd_addr[1] = 32'd7;  exp_rd[1] = 32'h0BAD_F00D;
        rd_addr[2] = 32'd0;  exp_rd[2] = 32'hA5A5_0000;
        rd_addr[3] = 32'd15; exp_rd[3] = 32'hA5A5_000F;
        p1_req = 1; p1_we = 0;
        for (int i = 0; i < 4; i++) begin
            p1_addr = rd_addr[i];
            wait_ack(1, 5, n);
            chk("t5_latency", n, (i == 0) ? 2 : 3);
            chk("t5_rdata", p1_rdata, exp_rd[i]);
            chk("t5_p0_quiet", p0_ack, 0);
        end
        p1_req = 0;
        tick();

        // Inputs changed during access must not reach the memory.
        p0_req = 1; p0_we = 1; p0_addr = 32'd9; p0_wdata = 32'h1111_2222;
        tick();
        p0_addr = 32'd10; p0_wdata = 32'h3333_4444;
        chk("t6_addr_latched", mem_addr, 32'd9);
        chk("t6_wdata_latched", mem_wdata, 32'h1111_2222);
        wait_ack(0, 4, n);
        p0_req = 0;
        tick();
        p0_txn(0, 32'd9, 32'h0, n);
        chk("t6_read9", p0_rdata, 32'h1111_2222);
        tick();
        p0_txn(0, 32'd10, 32'h0, n);
        chk("t6_read10", p0_rdata, 32'hA5A5_000A);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
